// File: rtl/piso_pkg.sv
// Shared definitions for the parallel-in/serial-out serializer: state encoding,
// default word width and the bit-counter width helper.
package piso_pkg;

    localparam int DEFAULT_WIDTH = 8;

    // Two-state FSM encoding, kept as plain constants for legacy tooling.
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    function automatic int cnt_bits(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Bit-position counter for the serializer: clears on load, steps on enable and
// wraps from WIDTH-1 back to 0; tc flags the last bit of a word.
module piso_bit_counter
    import piso_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CW    = cnt_bits(WIDTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic          enable,
    output logic [CW-1:0] count,
    output logic          tc
);

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    assign tc = (count == LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (enable) begin
            count <= tc ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer with frame markers, back-to-back word
// support and a shift enable that freezes the whole datapath.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             din_valid,
    input  logic [WIDTH-1:0] din,
    output logic             din_ready,
    output logic             dout,
    output logic             dout_valid,
    output logic             frame_start,
    output logic             frame_end,
    output logic [0:0]       fsm_state
);

    localparam int            CW     = cnt_bits(WIDTH);
    localparam logic [CW-1:0] PENULT = CW'(WIDTH - 2);

    logic [0:0]       state;
    logic [WIDTH-1:0] sreg;
    logic [CW-1:0]    cnt;
    logic             tc;
    logic             accept;
    logic             advance;

    function automatic logic head_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] drop_head(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? (w << 1) : (w >> 1);
    endfunction

    // Handshake: a word transfers on a rising edge where din_valid and din_ready
    // are both high; din_ready is combinational and only opens in IDLE or on the
    // enabled last-bit cycle, so din/din_valid are don't-care otherwise.
    assign din_ready = reset & ((state == ST_IDLE) | (tc & en));
    assign accept    = din_valid & din_ready;
    assign advance   = (state == ST_SHIFT) & en;
    assign fsm_state = state;

    piso_bit_counter #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_bit_counter (
        .clk    (clk),
        .reset  (reset),
        .load   (accept),
        .enable (advance),
        .count  (cnt),
        .tc     (tc)
    );

    // sreg holds the bits still to come; dout is the bit currently on the line.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            sreg        <= '0;
            dout        <= 1'b0;
            dout_valid  <= 1'b0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
        end else if (accept) begin
            state       <= ST_SHIFT;
            sreg        <= drop_head(din);
            dout        <= head_bit(din);
            dout_valid  <= 1'b1;
            frame_start <= 1'b1;
            frame_end   <= 1'b0;
        end else if (advance) begin
            if (tc) begin
                state       <= ST_IDLE;
                sreg        <= '0;
                dout        <= 1'b0;
                dout_valid  <= 1'b0;
                frame_start <= 1'b0;
                frame_end   <= 1'b0;
            end else begin
                sreg        <= drop_head(sreg);
                dout        <= head_bit(sreg);
                frame_start <= 1'b0;
                frame_end   <= (cnt == PENULT);
            end
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: MSB-first and LSB-first instances share stimulus and
// are compared against queue-based bit-stream models.
module tb_piso_serializer;

    logic       clk;
    logic       reset;
    logic       en;
    logic       din_valid;
    logic [7:0] din;

    logic       din_ready_m, dout_m, dout_valid_m, frame_start_m, frame_end_m;
    logic [0:0] st_m;
    logic       din_ready_l, dout_l, dout_valid_l, frame_start_l, frame_end_l;
    logic [0:0] st_l;

    int n_vec;
    int n_err;

    // Bits still to appear on dout, head = bit currently on the line.
    logic qm[$];
    logic ql[$];

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .din_valid   (din_valid),
        .din         (din),
        .din_ready   (din_ready_m),
        .dout        (dout_m),
        .dout_valid  (dout_valid_m),
        .frame_start (frame_start_m),
        .frame_end   (frame_end_m),
        .fsm_state   (st_m)
    );

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .din_valid   (din_valid),
        .din         (din),
        .din_ready   (din_ready_l),
        .dout        (dout_l),
        .dout_valid  (dout_valid_l),
        .frame_start (frame_start_l),
        .frame_end   (frame_end_l),
        .fsm_state   (st_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic model_ready();
        return (qm.size() == 0) || (qm.size() == 1 && en);
    endfunction

    task automatic check_outputs();
        logic busy;
        busy = (qm.size() > 0);
        check("dout_m",        dout_m,        busy ? qm[0] : 1'b0);
        check("dout_valid_m",  dout_valid_m,  busy);
        check("frame_start_m", frame_start_m, qm.size() == 8);
        check("frame_end_m",   frame_end_m,   qm.size() == 1);
        check("state_m",       st_m,          busy);
        check("dout_l",        dout_l,        busy ? ql[0] : 1'b0);
        check("dout_valid_l",  dout_valid_l,  busy);
        check("frame_start_l", frame_start_l, ql.size() == 8);
        check("frame_end_l",   frame_end_l,   ql.size() == 1);
    endtask

    task automatic reset_check();
        check("rst_din_ready_m", din_ready_m,  1'b0);
        check("rst_dout_m",      dout_m,       1'b0);
        check("rst_valid_m",     dout_valid_m, 1'b0);
        check("rst_fs_m",        frame_start_m, 1'b0);
        check("rst_fe_m",        frame_end_m,  1'b0);
        check("rst_state_m",     st_m,         1'b0);
        check("rst_din_ready_l", din_ready_l,  1'b0);
        check("rst_dout_l",      dout_l,       1'b0);
        check("rst_valid_l",     dout_valid_l, 1'b0);
    endtask

    // One clock: ready checked at the falling edge, model advanced at the rising
    // edge, registered outputs checked just after it. Inputs must be stable.
    task automatic tick();
        logic rdy;
        @(negedge clk);
        rdy = model_ready();
        check("din_ready_m", din_ready_m, rdy);
        check("din_ready_l", din_ready_l, rdy);
        @(posedge clk);
        if (en && qm.size() > 0) begin
            void'(qm.pop_front());
            void'(ql.pop_front());
        end
        if (din_valid && rdy) begin
            for (int i = 0; i < 8; i++) begin
                qm.push_back(din[7 - i]);
                ql.push_back(din[i]);
            end
        end
        #1;
        check_outputs();
    endtask

    // Frame markers may only accompany valid data; idle line must be low.
    always @(negedge clk) begin
        if (reset) begin
            check("mon_fs_m", frame_start_m & ~dout_valid_m, 1'b0);
            check("mon_fe_m", frame_end_m & ~dout_valid_m, 1'b0);
            check("mon_idle_m", dout_m & ~dout_valid_m, 1'b0);
            check("mon_fs_l", frame_start_l & ~dout_valid_l, 1'b0);
            check("mon_fe_l", frame_end_l & ~dout_valid_l, 1'b0);
        end
    end

    initial begin
        logic [7:0]  word_m;
        logic [7:0]  word_l;
        logic [15:0] stream;
        int          valid_cycles;

        n_vec     = 0;
        n_err     = 0;
        reset     = 1'b0;
        en        = 1'b1;
        din_valid = 1'b0;
        din       = 8'h00;

        // Reset state, asserted before any clock edge.
        #1;
        reset_check();
        repeat (3) @(posedge clk);
        #1;
        reset_check();
        @(negedge clk);
        #1 reset = 1'b1;
        tick();

        // Single word 8'hA5.
        din = 8'hA5; din_valid = 1'b1; en = 1'b1;
        word_m = '0; word_l = '0;
        for (int i = 0; i < 8; i++) begin
            tick();
            din_valid = 1'b0;
            word_m = {word_m[6:0], dout_m};
            word_l = {dout_l, word_l[7:1]};
        end
        check("a5_word_m", word_m, 8'hA5);
        check("a5_word_l", word_l, 8'hA5);
        tick();
        check("a5_idle_after", dout_valid_m, 1'b0);

        // Back-to-back 8'hF0 then 8'h0F with din_valid held high.
        din = 8'hF0; din_valid = 1'b1;
        stream = '0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (i == 0) din = 8'h0F;
            if (i == 8) din_valid = 1'b0;
            stream = {stream[14:0], dout_m};
        end
        check("b2b_stream", stream, 16'hF00F);
        tick();

        // Stall: en low for 3 cycles after bit 3 of 8'hC3.
        din = 8'hC3; din_valid = 1'b1;
        valid_cycles = 0;
        for (int i = 0; i < 13; i++) begin
            tick();
            din_valid = 1'b0;
            if (dout_valid_m) valid_cycles++;
            en = (i >= 2 && i <= 4) ? 1'b0 : 1'b1;
            if (i >= 3 && i <= 5) check("stall_hold_bit3", dout_m, 1'b0);
        end
        check("stall_span", valid_cycles, 11);

        // LSB-first instance with 8'h01.
        en = 1'b1; din = 8'h01; din_valid = 1'b1;
        word_l = '0;
        for (int i = 0; i < 8; i++) begin
            tick();
            din_valid = 1'b0;
            word_l = {word_l[6:0], dout_l};
        end
        check("lsb_01_order", word_l, 8'h80);
        tick();

        // Reset mid-frame after bit 4 of 8'hFF.
        din = 8'hFF; din_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            din_valid = 1'b0;
        end
        reset = 1'b0;
        #1;
        reset_check();
        qm.delete();
        ql.delete();
        @(negedge clk);
        #1 reset = 1'b1;
        for (int i = 0; i < 10; i++) tick();

        // Ignored input: din_valid/din toggle while din_ready is low.
        din = 8'h5A; din_valid = 1'b1;
        word_m = '0;
        for (int i = 0; i < 8; i++) begin
            tick();
            word_m = {word_m[6:0], dout_m};
            din_valid = (i < 6) ? 1'($urandom_range(0, 1)) : 1'b0;
            din = 8'($urandom);
        end
        check("ignored_word", word_m, 8'h5A);
        tick();

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            en        = ($urandom_range(0, 3) != 0);
            din_valid = 1'($urandom_range(0, 1));
            din       = 8'($urandom);
            tick();
        end
        din_valid = 1'b0;
        en = 1'b1;
        for (int i = 0; i < 10; i++) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, parallel word width in bits (legal range 2..32).
REQ-002 SHALL have parameter MSB_FIRST, default 1; 1 = shift MSB first, 0 = LSB first.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port en  input  1  shift enable; when low, all shifting and counting freeze.
REQ-006 SHALL have port din_valid  input  1  parallel word offered.
REQ-007 SHALL have port din  input  WIDTH  parallel word; sampled only on an accept.
REQ-008 SHALL have port din_ready  output  1  block can accept a word this cycle.
REQ-009 SHALL have port dout  output  1  registered serial bit.
REQ-010 SHALL have port dout_valid  output  1  dout carries a valid data bit.
REQ-011 SHALL have port frame_start  output  1  high while dout carries the first bit of a word.
REQ-012 SHALL have port frame_end  output  1  high while dout carries the last bit of a word.

Function
REQ-013 SHALL treat an accept as din_valid & din_ready at a rising clk edge.
REQ-014 SHALL implement a two-state FSM, IDLE and SHIFT; IDLE -> SHIFT on accept; SHIFT -> IDLE after the last bit is shifted with no new accept; SHIFT -> SHIFT when the last bit and a new accept coincide.
REQ-015 SHALL drive din_ready = 1 in IDLE, and = 1 in SHIFT only when the bit counter equals WIDTH-1 and en = 1; otherwise 0.
REQ-016 SHALL load the accepted word into a WIDTH-bit shift register and present the first bit on dout in the cycle after the accept edge (latency 1).
REQ-017 SHALL advance one bit per clk edge while en = 1, so a word occupies exactly WIDTH enabled cycles on dout.
REQ-018 SHALL, when en = 0, hold dout, dout_valid, frame_start, frame_end, the counter and the FSM state unchanged, and drive din_ready = 0 in SHIFT.
REQ-019 SHALL permit an accept in IDLE regardless of en; the first bit then appears in the next cycle.
REQ-020 SHALL send back-to-back words with no gap: the first bit of word N+1 immediately follows the last bit of word N.
REQ-021 SHALL keep the bit counter at ceil(log2(WIDTH)) bits, counting 0..WIDTH-1 and wrapping to 0 on load, never exceeding WIDTH-1.
REQ-022 SHALL drive dout_valid = 1 exactly during bits of a word and 0 in IDLE.
REQ-023 SHALL drive dout = 0 in IDLE.
REQ-024 SHALL assert frame_start only when the counter = 0 and frame_end only when the counter = WIDTH-1, both qualified by dout_valid.
REQ-025 SHALL ignore din and din_valid whenever din_ready = 0, with no state change.

Reset
REQ-026 SHALL, while reset = 0, force state = IDLE, counter = 0, shift register = 0, dout = 0, dout_valid = 0, frame_start = 0, frame_end = 0 and din_ready = 0, independent of clk.
REQ-027 SHALL abort a word in progress on reset assertion mid-frame, with no remaining bits emitted after release.
REQ-028 SHALL raise din_ready in the first cycle after reset deassertion (IDLE).

Structure
REQ-029 SHALL take its FSM state enum (IDLE, SHIFT) and the default WIDTH constant from a shared package, piso_pkg.
REQ-030 SHALL implement the bit counter as one sub-module, piso_bit_counter (load, enable, terminal-count output); all other logic stays in piso_serializer.
REQ-031 SHALL register every output except din_ready.

Verification
REQ-032 Single word: WIDTH=8, MSB_FIRST=1, en=1, accept din=8'hA5 -> dout = 1,0,1,0,0,1,0,1 on the 8 following cycles; frame_start on bit 1 and frame_end on bit 8; IDLE afterwards.
REQ-033 Back-to-back: din_valid held high with 8'hF0 then 8'h0F -> 16 contiguous valid bits 11110000 00001111; din_ready high only in the cycle of bit 8.
REQ-034 Stall: en held low for 3 cycles after bit 3 of 8'hC3 -> dout holds bit 3 for 4 cycles; total frame spans 11 cycles with the correct bit order.
REQ-035 LSB first: MSB_FIRST=0, accept 8'h01 -> dout = 1 followed by seven 0s.
REQ-036 Reset mid-frame: reset low after bit 4 of 8'hFF -> outputs 0 immediately (asynchronous); after release, din_ready = 1 and no residual bits appear.
REQ-037 Ignored input: din_valid toggling during SHIFT with din_ready = 0 -> transmitted word unchanged; the bench checks frame_start/frame_end with an assertion monitor.
